// File: rtl/axi_pkg.sv
// Shared AXI definitions for the slave (and the master that lives beside it).
// Contents: response codes and the slave write/read FSM state encodings.
// No ports.
package axi_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE    = 2'b00,
        W_HAVE_AW = 2'b01,
        W_HAVE_W  = 2'b10,
        W_RESP    = 2'b11
    } w_state_t;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_DATA = 1'b1
    } r_state_t;

endpackage

// File: rtl/axi_slv_regbank.sv
// Register bank for axi_slv: NREG words of DW bits, one synchronous write
// port, one combinational read port, and a flat view of all contents.
// Ports:
//   clk, rstn          clock, async active-low reset (clears every word)
//   we, waddr, wdata   write port, lands on the rising edge
//   raddr, rdata       read port, returns current (pre-edge) contents
//   regs               flat contents, word i at [i*DW +: DW]
module axi_slv_regbank #(
    parameter int DW   = 32,
    parameter int NREG = 4,
    parameter int IW   = $clog2(NREG)
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               we,
    input  logic [IW-1:0]      waddr,
    input  logic [DW-1:0]      wdata,
    input  logic [IW-1:0]      raddr,
    output logic [DW-1:0]      rdata,
    output logic [NREG*DW-1:0] regs
);

    logic [DW-1:0] mem [NREG];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < NREG; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

    for (genvar g = 0; g < NREG; g++) begin : g_flat
        assign regs[g*DW +: DW] = mem[g];
    end

endmodule

// File: rtl/axi_slv.sv
// AXI4-Lite style register slave: independent write and read FSMs in front
// of an NREG x DW register bank. Every output is a flop.
// Ports:
//   clk, rstn                          clock, async active-low reset
//   awvalid/awready/awaddr             write-address channel
//   wvalid/wready/wdata                write-data channel
//   bvalid/bready/bresp                write-response channel
//   arvalid/arready/araddr             read-address channel
//   rvalid/rready/rdata/rresp          read-data channel
//   regs                               flat register contents
//
// state      | meaning
// W_IDLE     | waiting for AW and/or W (awready=1, wready=1)
// W_HAVE_AW  | address latched, waiting for data (wready=1)
// W_HAVE_W   | data latched, waiting for address (awready=1)
// W_RESP     | write done, bvalid held until bready
// R_IDLE     | waiting for AR (arready=1)
// R_DATA     | rdata/rresp held with rvalid until rready
module axi_slv
    import axi_pkg::*;
#(
    parameter int AW   = 32,
    parameter int DW   = 32,
    parameter int NREG = 4
) (
    input  logic               clk,
    input  logic               rstn,
    input  logic               awvalid,
    output logic               awready,
    input  logic [AW-1:0]      awaddr,
    input  logic               wvalid,
    output logic               wready,
    input  logic [DW-1:0]      wdata,
    output logic               bvalid,
    input  logic               bready,
    output logic [1:0]         bresp,
    input  logic               arvalid,
    output logic               arready,
    input  logic [AW-1:0]      araddr,
    output logic               rvalid,
    input  logic               rready,
    output logic [DW-1:0]      rdata,
    output logic [1:0]         rresp,
    output logic [NREG*DW-1:0] regs
);

    localparam int IW = $clog2(NREG);

    // In range when the word address addr[AW-1:2] is below NREG, i.e. every
    // bit above the index field is zero.
    function automatic logic in_range(input logic [AW-1:0] a);
        return (a >> (2 + IW)) == '0;
    endfunction

    w_state_t      w_state, w_state_nxt;
    r_state_t      r_state, r_state_nxt;

    logic          awready_q, wready_q, bvalid_q, arready_q, rvalid_q;
    logic [1:0]    bresp_q, rresp_q;
    logic [DW-1:0] rdata_q;
    logic [AW-1:0] aw_addr_q;
    logic [DW-1:0] w_data_q;

    logic          aw_hs, w_hs, ar_hs;
    logic          commit, wr_en;
    logic [AW-1:0] cm_addr;
    logic [DW-1:0] cm_data;
    logic [DW-1:0] rd_word;

    assign aw_hs = awvalid & awready_q;
    assign w_hs  = wvalid & wready_q;
    assign ar_hs = arvalid & arready_q;

    // Write FSM: commit marks the edge entering W_RESP; the address/data
    // come from the live bus or the latched copy, whichever arrived last.
    always_comb begin
        w_state_nxt = w_state;
        commit      = 1'b0;
        cm_addr     = aw_addr_q;
        cm_data     = w_data_q;
        case (w_state)
            W_IDLE: begin
                if (aw_hs && w_hs) begin
                    w_state_nxt = W_RESP;
                    commit      = 1'b1;
                    cm_addr     = awaddr;
                    cm_data     = wdata;
                end else if (aw_hs) begin
                    w_state_nxt = W_HAVE_AW;
                end else if (w_hs) begin
                    w_state_nxt = W_HAVE_W;
                end
            end
            W_HAVE_AW: begin
                if (w_hs) begin
                    w_state_nxt = W_RESP;
                    commit      = 1'b1;
                    cm_data     = wdata;
                end
            end
            W_HAVE_W: begin
                if (aw_hs) begin
                    w_state_nxt = W_RESP;
                    commit      = 1'b1;
                    cm_addr     = awaddr;
                end
            end
            W_RESP: begin
                if (bvalid_q && bready) begin
                    w_state_nxt = W_IDLE;
                end
            end
            default: w_state_nxt = W_IDLE;
        endcase
    end

    assign wr_en = commit && in_range(cm_addr);

    // Readies/valid are registered from the next state so they track the
    // state flop exactly and come out of reset low, rising one edge later.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            w_state   <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            aw_addr_q <= '0;
            w_data_q  <= '0;
        end else begin
            w_state   <= w_state_nxt;
            awready_q <= (w_state_nxt == W_IDLE) || (w_state_nxt == W_HAVE_W);
            wready_q  <= (w_state_nxt == W_IDLE) || (w_state_nxt == W_HAVE_AW);
            bvalid_q  <= (w_state_nxt == W_RESP);
            if (commit) begin
                bresp_q <= in_range(cm_addr) ? RESP_OKAY : RESP_SLVERR;
            end
            if (aw_hs) begin
                aw_addr_q <= awaddr;
            end
            if (w_hs) begin
                w_data_q <= wdata;
            end
        end
    end

    always_comb begin
        r_state_nxt = r_state;
        case (r_state)
            R_IDLE:  if (ar_hs) r_state_nxt = R_DATA;
            R_DATA:  if (rvalid_q && rready) r_state_nxt = R_IDLE;
            default: r_state_nxt = R_IDLE;
        endcase
    end

    // The read samples the bank before the edge, so a write committing on
    // the same edge is not visible to it.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state   <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            r_state   <= r_state_nxt;
            arready_q <= (r_state_nxt == R_IDLE);
            rvalid_q  <= (r_state_nxt == R_DATA);
            if (ar_hs) begin
                rdata_q <= in_range(araddr) ? rd_word : '0;
                rresp_q <= in_range(araddr) ? RESP_OKAY : RESP_SLVERR;
            end
        end
    end

    axi_slv_regbank #(
        .DW   (DW),
        .NREG (NREG),
        .IW   (IW)
    ) u_regbank (
        .clk   (clk),
        .rstn  (rstn),
        .we    (wr_en),
        .waddr (cm_addr[2 +: IW]),
        .wdata (cm_data),
        .raddr (araddr[2 +: IW]),
        .rdata (rd_word),
        .regs  (regs)
    );

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;
    assign bresp   = bresp_q;
    assign arready = arready_q;
    assign rvalid  = rvalid_q;
    assign rdata   = rdata_q;
    assign rresp   = rresp_q;

endmodule

// File: tb/tb_axi_slv.sv
// Directed self-checking bench for axi_slv. Inputs change and outputs are
// sampled on the falling edge; expected responses are queued when a
// transaction is driven and popped when the DUT presents it.
module tb_axi_slv;
    import axi_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int NREG = 4;

    logic               clk = 1'b0;
    logic               rstn = 1'b0;
    logic               awvalid, awready;
    logic [AW-1:0]      awaddr;
    logic               wvalid, wready;
    logic [DW-1:0]      wdata;
    logic               bvalid, bready;
    logic [1:0]         bresp;
    logic               arvalid, arready;
    logic [AW-1:0]      araddr;
    logic               rvalid, rready;
    logic [DW-1:0]      rdata;
    logic [1:0]         rresp;
    logic [NREG*DW-1:0] regs;

    always #5 clk = ~clk;

    axi_slv #(.AW(AW), .DW(DW), .NREG(NREG)) dut (
        .clk     (clk),
        .rstn    (rstn),
        .awvalid (awvalid),
        .awready (awready),
        .awaddr  (awaddr),
        .wvalid  (wvalid),
        .wready  (wready),
        .wdata   (wdata),
        .bvalid  (bvalid),
        .bready  (bready),
        .bresp   (bresp),
        .arvalid (arvalid),
        .arready (arready),
        .araddr  (araddr),
        .rvalid  (rvalid),
        .rready  (rready),
        .rdata   (rdata),
        .rresp   (rresp),
        .regs    (regs)
    );

    typedef struct packed {
        logic [1:0]    resp;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          bq[$];
    exp_t          rq[$];
    logic [DW-1:0] mdl [NREG];
    exp_t          held;
    int            n_vec = 0;
    int            n_err = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NREG*DW-1:0] mdl_flat();
        logic [NREG*DW-1:0] f;
        for (int i = 0; i < NREG; i++) f[i*DW +: DW] = mdl[i];
        return f;
    endfunction

    function automatic logic mdl_in_range(input logic [AW-1:0] a);
        return (a >> 2) < NREG;
    endfunction

    // Drive AW and W together; expectation queued and model updated now.
    task automatic start_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        awvalid = 1'b1;
        awaddr  = a;
        wvalid  = 1'b1;
        wdata   = d;
        bq.push_back(exp_t'{mdl_in_range(a) ? RESP_OKAY : RESP_SLVERR, '0});
        if (mdl_in_range(a)) mdl[a[3:2]] = d;
    endtask

    task automatic start_read(input logic [AW-1:0] a);
        arvalid = 1'b1;
        araddr  = a;
        if (mdl_in_range(a)) rq.push_back(exp_t'{RESP_OKAY, mdl[a[3:2]]});
        else                 rq.push_back(exp_t'{RESP_SLVERR, '0});
    endtask

    task automatic pop_b(input string tag);
        exp_t e;
        if (bq.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s: response observed with no expectation queued", tag);
        end else begin
            e = bq.pop_front();
            chk({tag, "_bvalid"}, 128'(bvalid), 128'(1'b1));
            chk({tag, "_bresp"}, 128'(bresp), 128'(e.resp));
        end
    endtask

    task automatic pop_r(input string tag, output exp_t e);
        e = '0;
        if (rq.size() == 0) begin
            n_vec++;
            n_err++;
            $error("FAIL %s: read data observed with no expectation queued", tag);
        end else begin
            e = rq.pop_front();
            chk({tag, "_rvalid"}, 128'(rvalid), 128'(1'b1));
            chk({tag, "_rresp"}, 128'(rresp), 128'(e.resp));
            chk({tag, "_rdata"}, 128'(rdata), 128'(e.data));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        awvalid = 1'b0; awaddr = '0; wvalid = 1'b0; wdata = '0; bready = 1'b0;
        arvalid = 1'b0; araddr = '0; rready = 1'b0;
        for (int i = 0; i < NREG; i++) mdl[i] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_awready", 128'(awready), 128'(1'b0));
        chk("rst_wready", 128'(wready), 128'(1'b0));
        chk("rst_arready", 128'(arready), 128'(1'b0));
        chk("rst_bvalid", 128'(bvalid), 128'(1'b0));
        chk("rst_rvalid", 128'(rvalid), 128'(1'b0));
        chk("rst_rdata", 128'(rdata), 128'(0));
        chk("rst_regs", 128'(regs), 128'(0));
        rstn = 1'b1;
        #1 chk("rel_awready_low", 128'(awready), 128'(1'b0));
        @(negedge clk);
        chk("rel_awready", 128'(awready), 128'(1'b1));
        chk("rel_wready", 128'(wready), 128'(1'b1));
        chk("rel_arready", 128'(arready), 128'(1'b1));

        // AW and W together
        bready = 1'b1;
        start_write(32'h4, 32'hDEADBEEF);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        pop_b("wr_both");
        chk("wr_both_reg1", 128'(regs[63:32]), 128'(32'hDEADBEEF));
        @(negedge clk);
        chk("wr_both_bdone", 128'(bvalid), 128'(1'b0));
        chk("wr_both_ready", 128'({awready, wready}), 128'(2'b11));

        // W first, AW three cycles later
        wvalid = 1'b1; wdata = 32'h12345678;
        @(negedge clk);
        wvalid = 1'b0;
        chk("wfirst_wready", 128'(wready), 128'(1'b0));
        chk("wfirst_awready", 128'(awready), 128'(1'b1));
        repeat (2) begin
            @(negedge clk);
            chk("wfirst_wait_wready", 128'(wready), 128'(1'b0));
            chk("wfirst_wait_bvalid", 128'(bvalid), 128'(1'b0));
        end
        awvalid = 1'b1; awaddr = 32'h8;
        bq.push_back(exp_t'{RESP_OKAY, '0});
        mdl[2] = 32'h12345678;
        @(negedge clk);
        awvalid = 1'b0;
        pop_b("wfirst");
        chk("wfirst_regs", 128'(regs), 128'(mdl_flat()));
        @(negedge clk);
        chk("wfirst_single_b", 128'(bvalid), 128'(1'b0));

        // Read with rready held low
        rready = 1'b0;
        start_read(32'h4);
        @(negedge clk);
        arvalid = 1'b0;
        pop_r("rd_hold", held);
        chk("rd_hold_arready", 128'(arready), 128'(1'b0));
        repeat (4) begin
            @(negedge clk);
            chk("rd_hold_rvalid", 128'(rvalid), 128'(1'b1));
            chk("rd_hold_rdata", 128'(rdata), 128'(held.data));
            chk("rd_hold_arready", 128'(arready), 128'(1'b0));
        end
        rready = 1'b1;
        @(negedge clk);
        chk("rd_done_rvalid", 128'(rvalid), 128'(1'b0));
        chk("rd_done_arready", 128'(arready), 128'(1'b1));

        // Out-of-range write and read
        start_write(32'h40, 32'h55);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0;
        pop_b("wr_oor");
        chk("wr_oor_regs", 128'(regs), 128'(mdl_flat()));
        @(negedge clk);
        start_read(32'h40);
        @(negedge clk);
        arvalid = 1'b0;
        pop_r("rd_oor", held);
        @(negedge clk);
        chk("rd_oor_done", 128'(rvalid), 128'(1'b0));

        // Read and write of reg0 on the same edge
        start_read(32'h0);
        start_write(32'h0, 32'hA);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        pop_b("rw_same_b");
        pop_r("rw_same_r", held);
        chk("rw_same_regs", 128'(regs), 128'(mdl_flat()));
        @(negedge clk);
        chk("rw_same_done", 128'({bvalid, rvalid}), 128'(2'b00));

        // Reset while a response and read data are pending
        bready = 1'b0; rready = 1'b0;
        start_write(32'hC, 32'h77);
        start_read(32'h4);
        @(negedge clk);
        awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        pop_b("pre_rst_b");
        pop_r("pre_rst_r", held);
        chk("pre_rst_regs", 128'(regs), 128'(mdl_flat()));
        #1 rstn = 1'b0;
        for (int i = 0; i < NREG; i++) mdl[i] = '0;
        #1;
        chk("mid_rst_bvalid", 128'(bvalid), 128'(1'b0));
        chk("mid_rst_rvalid", 128'(rvalid), 128'(1'b0));
        chk("mid_rst_regs", 128'(regs), 128'(mdl_flat()));
        chk("mid_rst_ready", 128'({awready, wready, arready}), 128'(3'b000));
        bready = 1'b1; rready = 1'b1;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        #1 chk("rerel_ready_low", 128'({awready, wready, arready}), 128'(3'b000));
        @(negedge clk);
        chk("rerel_ready", 128'({awready, wready, arready}), 128'(3'b111));
        chk("rerel_bvalid", 128'(bvalid), 128'(1'b0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/axi_slv.md
AXI_SLV -- requirements
Module: axi_slv

Interface
REQ-001 SHALL have parameter AW, default 32, meaning address width.
REQ-002 SHALL have parameter DW, default 32, meaning data width.
REQ-003 SHALL have parameter NREG, default 4, meaning number of DW-bit registers (power of 2, 2..256).
REQ-004 clk  input  1  clock; all logic on rising edge.
REQ-005 rstn  input  1  reset, asynchronous, active-low.
REQ-006 awvalid/awready/awaddr  input/output/input  1/1/AW  write-address channel.
REQ-007 wvalid/wready/wdata  input/output/input  1/1/DW  write-data channel.
REQ-008 bvalid/bready/bresp  output/input/output  1/1/2  write-response channel.
REQ-009 arvalid/arready/araddr  input/output/input  1/1/AW  read-address channel.
REQ-010 rvalid/rready/rdata/rresp  output/input/output/output  1/1/DW/2  read-data channel.
REQ-011 regs  output  NREG*DW  flat register contents; register i occupies bits [i*DW +: DW].

Function
REQ-012 SHALL decode the word address as addr[AW-1:2]; addr[1:0] ignored; index = addr[2 +: log2(NREG)].
REQ-013 SHALL treat an address as in range only when addr[AW-1:2] < NREG; in range -> resp 2'b00 OKAY, otherwise 2'b10 SLVERR.
REQ-014 Write FSM states: W_IDLE (awready=1, wready=1), W_HAVE_AW (awready=0, wready=1), W_HAVE_W (awready=1, wready=0), W_RESP (both 0, bvalid=1).
REQ-015 W_IDLE: AW and W handshakes in the same cycle -> W_RESP; AW only -> W_HAVE_AW (awaddr latched); W only -> W_HAVE_W (wdata latched).
REQ-016 W_HAVE_AW: W handshake -> W_RESP; W_HAVE_W: AW handshake -> W_RESP.
REQ-017 SHALL update the addressed register at the clock edge entering W_RESP; out-of-range writes SHALL change no register.
REQ-018 bvalid SHALL assert the cycle after the completing handshake, with bresp stable, and hold until bvalid&bready; then W_IDLE, with readies high the next cycle.
REQ-019 Read FSM states: R_IDLE (arready=1, rvalid=0) and R_DATA (arready=0, rvalid=1).
REQ-020 R_IDLE with arvalid SHALL latch rdata/rresp from current register contents and enter R_DATA; rvalid SHALL assert the next cycle.
REQ-021 R_DATA SHALL hold rdata/rresp stable until rvalid&rready, then return to R_IDLE.
REQ-022 Out-of-range reads SHALL return rdata=0, rresp=2'b10.
REQ-023 Read and write FSMs SHALL be independent; a read handshake in the same cycle as a write commit to the same register SHALL return the pre-write value.
REQ-024 All handshake outputs SHALL be driven directly from flops (no combinational path from any input to any output).
REQ-025 The slave SHALL never drop valid without a handshake, and SHALL never change data while valid is high.

Reset
REQ-026 While rstn=0: awready=wready=arready=0, bvalid=rvalid=0, bresp=rresp=2'b00, rdata=0, all registers 0, FSMs in W_IDLE/R_IDLE.
REQ-027 awready, wready and arready SHALL rise on the first clock edge after rstn deasserts.
REQ-028 Reset asserted mid-transaction SHALL immediately abort it: pending bvalid/rvalid drop and no partial write lands.

Structure
REQ-029 AXI response codes (OKAY=2'b00, SLVERR=2'b10) and the FSM state encodings SHALL be placed in the shared package axi_pkg, alongside the master's.
REQ-030 The register bank (NREG x DW, one write port, one read port, flat output) SHALL be the sub-module axi_slv_regbank; the FSMs stay in axi_slv.

Verification
REQ-031 Write 0xDEADBEEF to 0x4 with AW and W together, bready=1 -> bvalid 1 cycle later, bresp=00, regs[63:32]=0xDEADBEEF.
REQ-032 W first, AW 3 cycles later (addr 0x8, data 0x12345678) -> wready low while waiting, single bvalid after AW, bresp=00, reg2 updated.
REQ-033 Read 0x4 after REQ-031, rready held low 4 cycles -> rvalid held, rdata=0xDEADBEEF stable, arready=0 until accepted.
REQ-034 Write 0x55 to 0x40 (NREG=4) -> bresp=10, all regs unchanged; read 0x40 -> rdata=0, rresp=10.
REQ-035 Write 0xA to reg0 and read reg0 with handshakes in the same cycle -> rdata=old value 0, reg0=0xA afterwards.
REQ-036 Assert rstn=0 while bvalid=1 and bready=0 -> bvalid and all regs 0 immediately; readies return 1 cycle after release.
